cn_minsum_serial: RTL and testbench

CN_MINSUM_SERIAL -- requirements
Module: cn_minsum_serial

---
 rtl/cn_pkg.sv | 30 +++
 rtl/cn_min2_tracker.sv | 58 +++++
 rtl/cn_minsum_serial.sv | 164 ++++++++++++++++
 tb/tb_cn_minsum_serial.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cn_pkg.sv
// Shared types and helpers for the serial offset-min-sum check-node unit.
package cn_pkg;

  // Check-node sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } cn_state_e;

  // Working width of the helpers; message widths up to this are supported
  localparam int unsigned HW = 32;

  // |x| saturated to 2^(w-1)-1 so the most negative code stays representable
  function automatic logic [HW-1:0] mag_sat(input logic signed [HW-1:0] x,
                                            input int unsigned          w);
    logic [HW-1:0] lim;
    logic [HW-1:0] a;
    lim = (HW'(1) << (w - 1)) - HW'(1);
    a   = x[HW-1] ? HW'(-x) : HW'(x);
    return (a > lim) ? lim : a;
  endfunction

  // Two's-complement negate r when s is set
  function automatic logic [HW-1:0] sign_apply(input logic [HW-1:0] r,
                                               input logic          s);
    return s ? (~r + HW'(1)) : r;
  endfunction

endpackage

// File: rtl/cn_min2_tracker.sv
// Running two-smallest-magnitude tracker with argmin; strict < keeps earlier argmin on ties.
module cn_min2_tracker
  import cn_pkg::*;
#(
  parameter int unsigned MW = 7,
  parameter int unsigned IW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd,
  input  logic          first,
  input  logic [MW-1:0] mag,
  input  logic [IW-1:0] idx,
  output logic [MW-1:0] min1,
  output logic [MW-1:0] min2,
  output logic [IW-1:0] argmin,
  output logic [MW-1:0] min1_c,
  output logic [MW-1:0] min2_c,
  output logic [IW-1:0] argmin_c
);

  localparam logic [MW-1:0] MAXV = '1;

  logic [MW-1:0] b1;
  logic [MW-1:0] b2;
  logic [IW-1:0] ba;

  // Next min pair including the current edge; first edge starts from the initial values
  always_comb begin
    b1       = first ? MAXV : min1;
    b2       = first ? MAXV : min2;
    ba       = first ? '0 : argmin;
    min1_c   = b1;
    min2_c   = b2;
    argmin_c = ba;
    if (mag < b1) begin
      min1_c   = mag;
      min2_c   = b1;
      argmin_c = idx;
    end else if (mag < b2) begin
      min2_c = mag;
    end
  end

  // Commit the update on each accepted edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min1   <= MAXV;
      min2   <= MAXV;
      argmin <= '0;
    end else if (upd) begin
      min1   <= min1_c;
      min2   <= min2_c;
      argmin <= argmin_c;
    end
  end

endmodule

// File: rtl/cn_minsum_serial.sv
// Serial offset-min-sum LDPC check node: accumulates v2c edges, then streams c2v edges in order.
// Optional build macro: CN_NORM_SCALE_EN adds a 3/4 normalisation of the clamped magnitude.
module cn_minsum_serial
  import cn_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned DEG_MAX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_msg,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [W-2:0] offset,
  output logic [W-1:0] out_msg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         deg_err
);

  localparam int unsigned MW = W - 1;
  localparam int unsigned IW = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1;
  localparam int unsigned CW = $clog2(DEG_MAX + 1);

  cn_state_e            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        out_idx;
  logic [DEG_MAX-1:0]   sign_buf;
  logic                 sign_xor;
  logic [MW-1:0]        offset_q;

  logic signed [W-1:0]  in_s;
  logic [MW-1:0]        mag_c;
  logic                 sgn_c;
  logic                 first_c;
  logic                 acc_c;
  logic [IW-1:0]        idx_c;
  logic                 term_c;
  logic [MW-1:0]        off_c;
  logic                 sx_c;
  logic                 s0_c;
  logic [IW-1:0]        nk_c;
  logic [W-1:0]         head_msg_c;
  logic                 head_last_c;
  logic [W-1:0]         next_msg_c;
  logic                 next_last_c;

  logic [MW-1:0] min1, min2, min1_c, min2_c;
  logic [IW-1:0] argmin, argmin_c;

  // c2v message for edge k from the min pair, sign parity and offset
  function automatic logic [W-1:0] edge_out(input logic [MW-1:0] m1,
                                            input logic [MW-1:0] m2,
                                            input logic [IW-1:0] am,
                                            input logic          sx,
                                            input logic          sk,
                                            input logic [MW-1:0] off,
                                            input logic [IW-1:0] k);
    logic [MW-1:0] m;
    logic [MW-1:0] r;
    m = (k == am) ? m2 : m1;
    r = (m > off) ? (m - off) : '0;
`ifdef CN_NORM_SCALE_EN
    r = r - (r >> 2);
`else
    r = r;
`endif
    return W'(sign_apply(HW'(r), sx ^ sk));
  endfunction

  assign in_s = in_msg;

  // Edge acceptance and head-of-stream output computed from the in-flight edge
  always_comb begin
    mag_c       = MW'(mag_sat(HW'(in_s), W));
    sgn_c       = in_msg[W-1];
    first_c     = (state == IDLE);
    acc_c       = in_valid && in_ready && (state != EMIT);
    idx_c       = first_c ? '0 : IW'(cnt);
    term_c      = in_last || (idx_c == IW'(DEG_MAX - 1));
    off_c       = first_c ? offset : offset_q;
    sx_c        = (first_c ? 1'b0 : sign_xor) ^ sgn_c;
    s0_c        = first_c ? sgn_c : sign_buf[0];
    nk_c        = out_idx + IW'(1);
    head_msg_c  = edge_out(min1_c, min2_c, argmin_c, sx_c, s0_c, off_c, '0);
    head_last_c = (idx_c == '0);
    next_msg_c  = edge_out(min1, min2, argmin, sign_xor, sign_buf[nk_c], offset_q, nk_c);
    next_last_c = (CW'(nk_c) == (cnt - CW'(1)));
  end

  cn_min2_tracker #(.MW(MW), .IW(IW)) u_min2 (
    .clk      (clk),
    .rst      (rst),
    .upd      (acc_c),
    .first    (first_c),
    .mag      (mag_c),
    .idx      (idx_c),
    .min1     (min1),
    .min2     (min2),
    .argmin   (argmin),
    .min1_c   (min1_c),
    .min2_c   (min2_c),
    .argmin_c (argmin_c)
  );

  // Node sequencing, sign buffering and registered output stream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_idx   <= '0;
      sign_buf  <= '0;
      sign_xor  <= 1'b0;
      offset_q  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_msg   <= '0;
      deg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          in_ready <= 1'b1;
          if (acc_c) begin
            sign_buf[idx_c] <= sgn_c;
            sign_xor        <= sx_c;
            offset_q        <= off_c;
            cnt             <= CW'(idx_c) + CW'(1);
            if (term_c) begin
              state     <= EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_msg   <= head_msg_c;
              out_last  <= head_last_c;
              out_idx   <= '0;
              if (!in_last) deg_err <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_msg   <= '0;
              in_ready  <= 1'b1;
            end else begin
              out_idx  <= nk_c;
              out_msg  <= next_msg_c;
              out_last <= next_last_c;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cn_minsum_serial.sv
// Scoreboard bench for cn_minsum_serial (W=8, DEG_MAX=4) with directed check-node vectors.
module tb_cn_minsum_serial;

`ifdef CN_NORM_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] in_msg;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [6:0] offset;
  logic [7:0] out_msg;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       deg_err;

  typedef struct {
    int msg;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   vin[8];
  int   total;
  int   bad;

  cn_minsum_serial #(.W(8), .DEG_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_msg    (in_msg),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .offset    (offset),
    .out_msg   (out_msg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .deg_err   (deg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  task automatic push_exp(input int m, input bit l);
    exp_t e;
    e.msg  = m;
    e.last = l;
    sb.push_back(e);
  endtask

  // Output monitor: pop and compare on every transfer
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0d want none", $signed(out_msg));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_msg", int'($signed(out_msg)), e.msg);
        chk("out_last", int'(out_last), int'(e.last));
      end
    end
  end

  // Drive n edges from vin; later edges carry a bogus offset that must be ignored
  task automatic send_node(input int n, input bit use_last, input bit exp_term,
                           input logic [6:0] off);
    for (int i = 0; i < n; i++) begin
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_msg   = 8'(vin[i]);
      in_last  = use_last && (i == n - 1);
      offset   = (i == 0) ? off : 7'd3;
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) fail_now("in_ready_wait");
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_term) chk("latency_out_valid", int'(out_valid), 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("drain");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_msg    = '0;
    in_last   = 1'b0;
    offset    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_msg", int'(out_msg), 0);
    chk("rst_deg_err", int'(deg_err), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);

    // {5,-3,7,2}, offset 0, followed back-to-back by {-128,4,4}, offset 1
    vin = '{5, -3, 7, 2, 0, 0, 0, 0};
    push_exp(-2, 0); push_exp(2, 0); push_exp(-2, 0); push_exp(-3, 1);
    send_node(4, 1, 1, 7'd0);
    vin = '{-128, 4, 4, 0, 0, 0, 0, 0};
    push_exp(3, 0); push_exp(-3, 0); push_exp(-3, 1);
    send_node(3, 1, 1, 7'd1);
    drain();

    // zero-magnitude edge
    vin = '{0, 6, -9, 0, 0, 0, 0, 0};
    push_exp(SCALE ? -5 : -6, 0); push_exp(0, 0); push_exp(0, 1);
    send_node(3, 1, 1, 7'd0);
    drain();

    // single-edge node: only min2 (initial max) is available
    vin = '{-7, 0, 0, 0, 0, 0, 0, 0};
    push_exp(SCALE ? 96 : 127, 1);
    send_node(1, 1, 1, 7'd0);
    drain();

    // offset larger than min1 clamps to zero
    vin = '{3, -10, 0, 0, 0, 0, 0, 0};
    push_exp(SCALE ? -4 : -5, 0); push_exp(0, 1);
    send_node(2, 1, 1, 7'd5);
    drain();

    // backpressure: output holds, no input accepted
    @(posedge clk); #1 out_ready = 1'b0;
    vin = '{5, -3, 7, 2, 0, 0, 0, 0};
    push_exp(-2, 0); push_exp(2, 0); push_exp(-2, 0); push_exp(-3, 1);
    send_node(4, 1, 1, 7'd0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_out_msg", int'($signed(out_msg)), -2);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();
    chk("no_deg_err_yet", int'(deg_err), 0);

    // DEG_MAX edges without in_last terminate the node
    vin = '{1, 2, 3, 4, 0, 0, 0, 0};
    push_exp(2, 0); push_exp(1, 0); push_exp(1, 0); push_exp(1, 1);
    send_node(4, 0, 1, 7'd0);
    drain();
    chk("deg_err_set", int'(deg_err), 1);

    // deg_err stays set across a normal node
    vin = '{5, -3, 7, 2, 0, 0, 0, 0};
    push_exp(-2, 0); push_exp(2, 0); push_exp(-2, 0); push_exp(-3, 1);
    send_node(4, 1, 1, 7'd0);
    drain();
    chk("deg_err_sticky", int'(deg_err), 1);

    // reset mid-ACCUM discards the partial node
    vin = '{9, 9, 0, 0, 0, 0, 0, 0};
    send_node(2, 0, 0, 7'd0);
    chk("accum_no_out", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clears_deg_err", int'(deg_err), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vin = '{0, 6, -9, 0, 0, 0, 0, 0};
    push_exp(SCALE ? -5 : -6, 0); push_exp(0, 0); push_exp(0, 1);
    send_node(3, 1, 1, 7'd0);
    drain();

    // reset mid-EMIT kills the stream immediately
    @(posedge clk); #1 out_ready = 1'b0;
    vin = '{1, 2, 3, 4, 0, 0, 0, 0};
    send_node(4, 0, 1, 7'd0);
    chk("emit_deg_err", int'(deg_err), 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("mid_emit_out_valid", int'(out_valid), 0);
    chk("mid_emit_deg_err", int'(deg_err), 0);
    chk("mid_emit_out_last", int'(out_last), 0);
    chk("mid_emit_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(out_valid), 0);
    end

    // normal operation after reset
    vin = '{5, -3, 7, 2, 0, 0, 0, 0};
    push_exp(-2, 0); push_exp(2, 0); push_exp(-2, 0); push_exp(-3, 1);
    send_node(4, 1, 1, 7'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
